// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter with optional two's-complement sign.
// Latency: BIN_W cycles from input accept to bcd_vld; sustained rate one result per BIN_W+1 cycles.
// Backpressure: result held in DONE until bcd_rdy; bin_rdy only while idle or while the result drains.
module bin2bcd_iter #(
    parameter int BIN_W  = 11,
    parameter int SIGNED = 1,
    parameter int DIG_N  = 4,
    localparam int OUT_W = SIGNED + 4*DIG_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             bin_vld,
    output logic             bin_rdy,
    output logic [OUT_W-1:0] bcd,
    output logic             bcd_vld,
    input  logic             bcd_rdy,
    output logic             bcd_ovf
);

    localparam int ACC_W = 4*DIG_N;
    localparam int CNT_W = $clog2(BIN_W+1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] bcd_q, bcd_d;
    logic             bcd_vld_q, bcd_vld_d;
    logic             bcd_ovf_q, bcd_ovf_d;

    logic             in_hs;
    logic             in_neg;
    logic [BIN_W-1:0] in_mag;
    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_shl;
    logic [BIN_W-1:0] mag_shl;
    logic             carry_out;
    logic             step_ovf;
    logic [ACC_W-1:0] res_dig;
    logic             res_sign;
    logic [OUT_W-1:0] res_word;

    // Accept new work when idle, or when the pending result leaves this same cycle.
    assign bin_rdy = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && bcd_rdy));
    assign in_hs   = bin_vld && bin_rdy;

    // Magnitude as unsigned BIN_W bits: the most negative input maps to 2^(BIN_W-1) without wrap.
    assign in_neg  = (SIGNED != 0) && bin[BIN_W-1];
    assign in_mag  = in_neg ? (~bin + BIN_W'(1)) : bin;

    // Double-dabble correction: any digit >= 5 gets +3 so the following shift carries decimally.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIG_N; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A 1 leaving the top digit means the value no longer fits in DIG_N digits; keep it sticky.
    assign {carry_out, acc_shl, mag_shl} = {acc_adj, mag_q, 1'b0};
    assign step_ovf = ovf_q | carry_out;

    // Final-step result: saturate to all nines on overflow; zero magnitude never reports a sign.
    assign res_dig  = step_ovf ? {DIG_N{4'h9}} : acc_shl;
    assign res_sign = sign_q & (step_ovf | (acc_shl != '0));
    assign res_word = OUT_W'({res_sign, res_dig});

    // Next-state logic: conversion steps, result drain, and input load (load wins as it only occurs in IDLE/DONE).
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        bcd_vld_d = bcd_vld_q;
        bcd_ovf_d = bcd_ovf_q;

        case (state_q)
            S_IDLE: begin
            end
            S_CONV: begin
                acc_d = acc_shl;
                mag_d = mag_shl;
                ovf_d = step_ovf;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d   = S_DONE;
                    bcd_d     = res_word;
                    bcd_vld_d = 1'b1;
                    bcd_ovf_d = step_ovf;
                end
            end
            S_DONE: begin
                if (bcd_rdy) begin
                    bcd_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_hs) begin
            sign_d  = in_neg;
            mag_d   = in_mag;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = S_CONV;
        end
    end

    // State registers with synchronous reset; reset discards any conversion or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            bcd_vld_q <= 1'b0;
            bcd_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            bcd_vld_q <= bcd_vld_d;
            bcd_ovf_q <= bcd_ovf_d;
        end
    end

    assign bcd     = bcd_q;
    assign bcd_vld = bcd_vld_q;
    assign bcd_ovf = bcd_ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Bench for bin2bcd_iter: default signed instance plus an unsigned 14-bit instance.
// Expected results come from a decimal-arithmetic model of sign, magnitude and saturation.
// Scenarios: reset, directed values, unsigned overflow, backpressure, back-to-back sweep, mid-op reset, random stress.
module tb_bin2bcd_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [10:0] bin;
    logic        bin_vld;
    logic        bin_rdy;
    logic [16:0] bcd;
    logic        bcd_vld;
    logic        bcd_rdy;
    logic        bcd_ovf;

    logic [13:0] u_bin;
    logic        u_bin_vld;
    logic        u_bin_rdy;
    logic [15:0] u_bcd;
    logic        u_bcd_vld;
    logic        u_bcd_rdy;
    logic        u_bcd_ovf;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    bin2bcd_iter dut (
        .clk     (clk),
        .rst     (rst),
        .bin     (bin),
        .bin_vld (bin_vld),
        .bin_rdy (bin_rdy),
        .bcd     (bcd),
        .bcd_vld (bcd_vld),
        .bcd_rdy (bcd_rdy),
        .bcd_ovf (bcd_ovf)
    );

    bin2bcd_iter #(.BIN_W(14), .SIGNED(0), .DIG_N(4)) dut_u (
        .clk     (clk),
        .rst     (rst),
        .bin     (u_bin),
        .bin_vld (u_bin_vld),
        .bin_rdy (u_bin_rdy),
        .bcd     (u_bcd),
        .bcd_vld (u_bcd_vld),
        .bcd_rdy (u_bcd_rdy),
        .bcd_ovf (u_bcd_ovf)
    );

    // Reference: signed 11-bit value -> {ovf, sign, 4 decimal digits}.
    function automatic logic [17:0] model_s(input int v);
        int          m;
        int          p;
        logic [16:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        p = m;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        if (m >= 10000) r[15:0] = 16'h9999;
        r[16] = (v < 0) && (m != 0);
        return {m >= 10000, r};
    endfunction

    // Reference: unsigned value -> {ovf, 4 decimal digits}.
    function automatic logic [16:0] model_u(input int m);
        int          p;
        logic [15:0] r;
        r = '0;
        p = m;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        if (m >= 10000) r = 16'h9999;
        return {m >= 10000, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer v on the signed instance until accepted; returns at the accept edge + 1.
    task automatic send(input logic [10:0] v, output logic accepted);
        bin      = v;
        bin_vld  = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 100 && !accepted; n++) begin
            if (bin_rdy) accepted = 1'b1;
            tick();
        end
        bin_vld = 1'b0;
    endtask

    task automatic wait_vld(output int lat);
        lat = 0;
        while (!bcd_vld && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        logic acc;
        int   lat;
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bin_rdy !== 1'b0 || bcd_vld !== 1'b0 || bcd !== 17'h0 || bcd_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b vld=%b bcd=%h ovf=%b, want 0 0 00000 0", bin_rdy, bcd_vld, bcd, bcd_ovf);
        end
        tests_run++;
        if (u_bcd_vld !== 1'b0 || u_bcd !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_state_u: vld=%b bcd=%h, want 0 0000", u_bcd_vld, u_bcd);
        end
        rst     = 1'b0;
        bin     = 11'd5;
        bin_vld = 1'b1;
        bcd_rdy = 1'b1;
        #1;
        tests_run++;
        if (bin_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rdy_after_reset: bin_rdy=%b want 1", bin_rdy);
        end
        @(posedge clk);
        #1;
        cyc++;
        bin_vld = 1'b0;
        tests_run++;
        if (bin_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_edge_accept: bin_rdy=%b want 0 (converting)", bin_rdy);
        end
        wait_vld(lat);
        tests_run++;
        if (bcd !== 17'h00005 || lat !== 11) begin
            tests_failed++;
            $display("FAIL first_edge_result: bcd=%h lat=%0d want 00005 lat 11", bcd, lat);
        end
        tick();
        acc = 1'b0;
    endtask

    task automatic test_directed();
        logic [10:0] vals [4];
        logic [16:0] exps [4];
        logic        acc;
        int          lat;
        vals[0] = 11'd1023; exps[0] = 17'h01023;
        vals[1] = 11'h400;  exps[1] = 17'h11024;
        vals[2] = 11'h7FF;  exps[2] = 17'h10001;
        vals[3] = 11'd0;    exps[3] = 17'h00000;
        bcd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vals[i], acc);
            tests_run++;
            if (acc !== 1'b1) begin
                tests_failed++;
                $display("FAIL directed_accept[%0d]: accepted=%b want 1", i, acc);
            end
            wait_vld(lat);
            tests_run++;
            if (lat !== 11) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: %0d cycles want 11", i, lat);
            end
            tests_run++;
            if (bcd !== exps[i] || bcd_ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_value[%0d]: bcd=%h ovf=%b want %h 0", i, bcd, bcd_ovf, exps[i]);
            end
            tick();
            tests_run++;
            if (bcd_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_consume[%0d]: bcd_vld=%b want 0", i, bcd_vld);
            end
        end
    endtask

    task automatic test_unsigned();
        int          vals [12];
        logic [16:0] e;
        logic        got;
        int          lat;
        vals[0] = 16383;
        vals[1] = 9999;
        vals[2] = 10000;
        vals[3] = 0;
        for (int i = 4; i < 12; i++) vals[i] = $urandom_range(0, 16383);
        u_bcd_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            u_bin     = 14'(vals[i]);
            u_bin_vld = 1'b1;
            got       = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                if (u_bin_rdy) got = 1'b1;
                tick();
            end
            u_bin_vld = 1'b0;
            lat = 0;
            while (!u_bcd_vld && lat < 100) begin
                tick();
                lat++;
            end
            tests_run++;
            if (got !== 1'b1 || lat !== 14) begin
                tests_failed++;
                $display("FAIL unsigned_latency[%0d]: accepted=%b lat=%0d want 1 14", i, got, lat);
            end
            if (i == 0)      e = {1'b1, 16'h9999};
            else if (i == 1) e = {1'b0, 16'h9999};
            else             e = model_u(vals[i]);
            tests_run++;
            if ({u_bcd_ovf, u_bcd} !== e) begin
                tests_failed++;
                $display("FAIL unsigned_value[%0d] bin=%0d: ovf,bcd=%h want %h", i, vals[i], {u_bcd_ovf, u_bcd}, e);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic        acc;
        int          lat;
        int          v;
        logic [16:0] held;
        logic [17:0] e;
        v = -345;
        e = model_s(v);
        bcd_rdy = 1'b0;
        send(v[10:0], acc);
        wait_vld(lat);
        tests_run++;
        if (lat !== 11 || {bcd_ovf, bcd} !== e) begin
            tests_failed++;
            $display("FAIL bp_result: lat=%0d ovf,bcd=%h want 11 %h", lat, {bcd_ovf, bcd}, e);
        end
        held    = bcd;
        bin     = 11'd7;
        bin_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bcd_vld !== 1'b1 || bcd !== e[16:0] || bin_rdy !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: vld=%b bcd=%h rdy=%b want 1 %h 0", i, bcd_vld, bcd, bin_rdy, e[16:0]);
            end
            tick();
        end
        tests_run++;
        if (bcd !== held) begin
            tests_failed++;
            $display("FAIL bp_stable: bcd=%h want %h", bcd, held);
        end
        bin_vld = 1'b0;
        bcd_rdy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bcd_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_once[%0d]: bcd_vld=%b want 0", i, bcd_vld);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] expq [$];
        logic [17:0] e;
        int          idx;
        int          v;
        int          last_out;
        int          guard;
        logic        hs;
        idx      = 0;
        last_out = -1;
        guard    = 0;
        bcd_rdy  = 1'b1;
        v        = -1024;
        bin      = v[10:0];
        bin_vld  = 1'b1;
        while ((idx < 2048 || expq.size() > 0) && guard < 30000) begin
            if (bcd_vld) begin
                tests_run++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_spurious: unexpected result %h", bcd);
                end else begin
                    e = expq.pop_front();
                    if ({bcd_ovf, bcd} !== e) begin
                        tests_failed++;
                        $display("FAIL b2b_value: ovf,bcd=%h want %h", {bcd_ovf, bcd}, e);
                    end
                end
                if (last_out >= 0) begin
                    tests_run++;
                    if (cyc - last_out !== 12) begin
                        tests_failed++;
                        $display("FAIL b2b_interval: %0d cycles want 12", cyc - last_out);
                    end
                end
                last_out = cyc;
            end
            hs = bin_vld && bin_rdy;
            tick();
            guard++;
            if (hs) begin
                expq.push_back(model_s(-1024 + idx));
                idx++;
                if (idx < 2048) begin
                    v   = -1024 + idx;
                    bin = v[10:0];
                end else begin
                    bin_vld = 1'b0;
                end
            end
        end
        bin_vld = 1'b0;
        tests_run++;
        if (idx !== 2048 || expq.size() !== 0) begin
            tests_failed++;
            $display("FAIL b2b_complete: sent=%0d pending=%0d want 2048 0", idx, expq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic        acc;
        int          lat;
        int          v;
        int          stale;
        logic [17:0] e;
        bcd_rdy = 1'b1;
        send(11'd777, acc);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (bin_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_rdy: bin_rdy=%b want 0", bin_rdy);
        end
        tick();
        rst = 1'b0;
        tests_run++;
        if (bcd_vld !== 1'b0 || bcd !== 17'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: vld=%b bcd=%h want 0 00000", bcd_vld, bcd);
        end
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            if (bcd_vld) stale++;
            tick();
        end
        tests_run++;
        if (stale !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_stale: %0d cycles of bcd_vld want 0", stale);
        end
        v = -999;
        e = model_s(v);
        send(v[10:0], acc);
        wait_vld(lat);
        tests_run++;
        if (lat !== 11 || {bcd_ovf, bcd} !== e) begin
            tests_failed++;
            $display("FAIL rst_mid_next: lat=%0d ovf,bcd=%h want 11 %h", lat, {bcd_ovf, bcd}, e);
        end
        tick();
        bcd_rdy = 1'b0;
        send(11'd321, acc);
        wait_vld(lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bcd_vld !== 1'b0 || bcd !== 17'h0) begin
            tests_failed++;
            $display("FAIL rst_done_clear: vld=%b bcd=%h want 0 00000", bcd_vld, bcd);
        end
        bcd_rdy = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [17:0] expq [$];
        logic [17:0] e;
        int          sent;
        int          got;
        int          guard;
        int          v;
        int          v_cur;
        logic        hs;
        sent  = 0;
        got   = 0;
        guard = 0;
        v_cur = 0;
        while ((sent < 300 || expq.size() > 0) && guard < 20000) begin
            v       = int'($urandom_range(0, 2047)) - 1024;
            bin     = v[10:0];
            bin_vld = (sent < 300) && ($urandom_range(0, 3) != 0);
            bcd_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (bcd_vld && bcd_rdy) begin
                tests_run++;
                got++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_duplicate: extra result %h", bcd);
                end else begin
                    e = expq.pop_front();
                    if ({bcd_ovf, bcd} !== e) begin
                        tests_failed++;
                        $display("FAIL rand_value[%0d]: ovf,bcd=%h want %h", got, {bcd_ovf, bcd}, e);
                    end
                end
            end
            hs    = bin_vld && bin_rdy;
            v_cur = v;
            tick();
            guard++;
            if (hs) begin
                expq.push_back(model_s(v_cur));
                sent++;
            end
        end
        bin_vld = 1'b0;
        bcd_rdy = 1'b1;
        tests_run++;
        if (sent !== 300 || got !== 300 || expq.size() !== 0) begin
            tests_failed++;
            $display("FAIL rand_count: sent=%0d received=%0d pending=%0d want 300 300 0", sent, got, expq.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bin       = '0;
        bin_vld   = 1'b0;
        bcd_rdy   = 1'b0;
        u_bin     = '0;
        u_bin_vld = 1'b0;
        u_bcd_rdy = 1'b1;
        test_reset();
        test_directed();
        test_unsigned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
